// File: rtl/mac_pkg.sv
// Shared MAC definitions: header geometry, frame limits and the egress FSM
// state encoding. The ingress decoder also imports this package.
package mac_pkg;

    localparam int HDR_W     = 112;
    localparam int HDR_BYTES = 14;
    localparam int MAX_FRAME = 1514;

    // Byte offsets of the header fields in wire order (dst goes out first)
    localparam int DST_BYTE  = 0;
    localparam int SRC_BYTE  = 6;
    localparam int TYPE_BYTE = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_DRAIN,
        ST_END
    } mac_state_t;

endpackage

// File: rtl/mac_enc.sv
// Egress frame serializer. Pops one header entry, streams the 14 header bytes
// and then the payload bytes into every PHY TX FIFO selected by the port mask.
// A single pass serves unicast and multicast alike; mask 0 drops the frame.
module mac_enc
    import mac_pkg::*;
#(
    parameter int NPORT       = 4,
    parameter int MAX_PAYLOAD = 1500,
    parameter int PLW         = 11
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [HDR_W-1:0]  h_fifo_dout,
    input  logic [NPORT-1:0]  h_fifo_mask,
    input  logic              h_fifo_empty,
    output logic              h_fifo_rden,
    input  logic [7:0]        b_fifo_dout,
    input  logic              b_fifo_del,
    input  logic              b_fifo_empty,
    output logic              b_fifo_rden,
    output logic [7:0]        o_fifo_din,
    output logic [NPORT-1:0]  o_fifo_wren,
    output logic              o_fifo_del,
    input  logic [NPORT-1:0]  o_fifo_afull,
    output logic              frame_done,
    output logic              frame_trunc
);

    mac_state_t        state;
    logic [HDR_W-1:0]  hdr_sr;
    logic [NPORT-1:0]  mask_reg;
    logic [3:0]        hdr_cnt;
    logic [PLW-1:0]    pay_cnt;

    logic              start;
    logic              pay_last;

    // A frame is admitted only when none of its destination ports is nearly
    // full; every admitted port then has room for a maximum-size frame, so
    // almost-full never needs to be looked at again until the next header.
    assign start       = (state == ST_IDLE) && !h_fifo_empty &&
                         ((h_fifo_mask & o_fifo_afull) == '0);
    assign h_fifo_rden = start;
    assign b_fifo_rden = ((state == ST_PAYLOAD) || (state == ST_DRAIN)) && !b_fifo_empty;
    assign pay_last    = (pay_cnt == PLW'(MAX_PAYLOAD - 1));

    // Frame FSM with header shifter, payload counter and registered TX outputs
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= ST_IDLE;
            hdr_sr      <= '0;
            mask_reg    <= '0;
            hdr_cnt     <= '0;
            pay_cnt     <= '0;
            o_fifo_din  <= '0;
            o_fifo_wren <= '0;
            o_fifo_del  <= 1'b0;
            frame_done  <= 1'b0;
            frame_trunc <= 1'b0;
        end else begin
            o_fifo_wren <= '0;
            o_fifo_del  <= 1'b0;
            frame_done  <= 1'b0;
            frame_trunc <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        hdr_sr   <= h_fifo_dout;
                        mask_reg <= h_fifo_mask;
                        hdr_cnt  <= '0;
                        state    <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    o_fifo_din  <= hdr_sr[HDR_W-1 -: 8];
                    o_fifo_wren <= mask_reg;
                    hdr_sr      <= {hdr_sr[HDR_W-9:0], 8'h00};
                    hdr_cnt     <= hdr_cnt + 1'b1;
                    if (hdr_cnt == 4'(HDR_BYTES - 1)) begin
                        state <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (!b_fifo_empty) begin
                        o_fifo_din  <= b_fifo_dout;
                        o_fifo_wren <= mask_reg;
                        pay_cnt     <= pay_cnt + 1'b1;
                        if (b_fifo_del) begin
                            o_fifo_del <= 1'b1;
                            frame_done <= 1'b1;
                            state      <= ST_END;
                        end else if (pay_last) begin
                            o_fifo_del  <= 1'b1;
                            frame_trunc <= 1'b1;
                            state       <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!b_fifo_empty && b_fifo_del) begin
                        frame_done <= 1'b1;
                        state      <= ST_END;
                    end
                end
                ST_END: begin
                    hdr_cnt  <= '0;
                    pay_cnt  <= '0;
                    mask_reg <= '0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_enc.sv
// Directed bench for mac_enc. Two instances: u_a with default parameters and
// u_b with MAX_PAYLOAD=16 for truncation. FWFT header/body FIFOs are modelled
// with arrays and read pointers; every TX write is logged for later checking.
module tb_mac_enc;
    import mac_pkg::*;

    localparam logic [111:0] HDR = 112'h0102030405060708090A0B0C0D0E;

    logic clk = 1'b0;
    logic arst_n;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [111:0] h_dout [2];
    logic [3:0]   h_mask [2];
    logic         h_empty[2];
    logic         h_rden [2];
    logic [7:0]   b_dout [2];
    logic         b_del  [2];
    logic         b_empty[2];
    logic         b_rden [2];
    logic [7:0]   o_din  [2];
    logic [3:0]   o_wren [2];
    logic         o_del  [2];
    logic [3:0]   afull  [2];
    logic         done   [2];
    logic         trunc  [2];

    logic [111:0] hmem[2][32];
    logic [3:0]   mmem[2][32];
    logic [7:0]   bmem[2][4096];
    logic         bdm [2][4096];
    int           hwr[2], hrd[2], bwr[2], brd[2], hold[2], stall_idx[2];

    logic [7:0]   wdin [2][1024];
    logic [3:0]   wmask[2][1024];
    logic         wdel [2][1024];
    int           wcyc [2][1024];
    int           wcnt[2], done_cnt[2], trunc_cnt[2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mac_enc u_a (
        .clk(clk), .arst_n(arst_n),
        .h_fifo_dout(h_dout[0]), .h_fifo_mask(h_mask[0]), .h_fifo_empty(h_empty[0]), .h_fifo_rden(h_rden[0]),
        .b_fifo_dout(b_dout[0]), .b_fifo_del(b_del[0]), .b_fifo_empty(b_empty[0]), .b_fifo_rden(b_rden[0]),
        .o_fifo_din(o_din[0]), .o_fifo_wren(o_wren[0]), .o_fifo_del(o_del[0]), .o_fifo_afull(afull[0]),
        .frame_done(done[0]), .frame_trunc(trunc[0])
    );

    mac_enc #(.NPORT(4), .MAX_PAYLOAD(16), .PLW(11)) u_b (
        .clk(clk), .arst_n(arst_n),
        .h_fifo_dout(h_dout[1]), .h_fifo_mask(h_mask[1]), .h_fifo_empty(h_empty[1]), .h_fifo_rden(h_rden[1]),
        .b_fifo_dout(b_dout[1]), .b_fifo_del(b_del[1]), .b_fifo_empty(b_empty[1]), .b_fifo_rden(b_rden[1]),
        .o_fifo_din(o_din[1]), .o_fifo_wren(o_wren[1]), .o_fifo_del(o_del[1]), .o_fifo_afull(afull[1]),
        .frame_done(done[1]), .frame_trunc(trunc[1])
    );

    // FIFO read side: advance pointers on DUT pops, flush on reset, and hold
    // the body FIFO empty for 5 cycles once the stall index has been popped
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!arst_n) begin
                hrd[d]  <= hwr[d];
                brd[d]  <= bwr[d];
                hold[d] <= 0;
            end else begin
                if (h_rden[d] === 1'b1) hrd[d] <= hrd[d] + 1;
                if (b_rden[d] === 1'b1) brd[d] <= brd[d] + 1;
                if (b_rden[d] === 1'b1 && (brd[d] + 1) == stall_idx[d]) hold[d] <= 5;
                else if (hold[d] > 0) hold[d] <= hold[d] - 1;
            end
        end
    end

    // FWFT output refresh and TX write logger, both away from the active edge
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            h_empty[d] <= (hrd[d] == hwr[d]);
            h_dout[d]  <= hmem[d][hrd[d] % 32];
            h_mask[d]  <= mmem[d][hrd[d] % 32];
            b_empty[d] <= (brd[d] == bwr[d]) || (hold[d] > 0);
            b_dout[d]  <= bmem[d][brd[d] % 4096];
            b_del[d]   <= bdm[d][brd[d] % 4096];
            if (o_wren[d] !== 4'h0 && wcnt[d] < 1024) begin
                wdin[d][wcnt[d]]  <= o_din[d];
                wmask[d][wcnt[d]] <= o_wren[d];
                wdel[d][wcnt[d]]  <= o_del[d];
                wcyc[d][wcnt[d]]  <= cyc;
                wcnt[d]           <= wcnt[d] + 1;
            end
            if (done[d] === 1'b1)  done_cnt[d]  <= done_cnt[d] + 1;
            if (trunc[d] === 1'b1) trunc_cnt[d] <= trunc_cnt[d] + 1;
        end
    end

    // Expected k-th byte of a frame's TX stream: header bytes MSB first, then payload
    function automatic logic [7:0] exp_byte(input logic [111:0] hdr, input logic [7:0] base, input int k);
        if (k < 14) return hdr[111 - 8*k -: 8];
        return base + 8'(k - 14);
    endfunction

    task automatic push_frame(input int d, input logic [3:0] mask, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            bmem[d][bwr[d] + i] = base + 8'(i);
            bdm[d][bwr[d] + i]  = (i == n - 1);
        end
        bwr[d] = bwr[d] + n;
        hmem[d][hwr[d]] = HDR;
        mmem[d][hwr[d]] = mask;
        hwr[d] = hwr[d] + 1;
    endtask

    task automatic wait_done(input int d, input int target, input int budget);
        int n = 0;
        while (done_cnt[d] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (done_cnt[d] < target) begin
            tests_failed++;
            $display("[TB] FAIL frame_done_timeout[%0d]: got %0d frames, expected %0d", d, done_cnt[d], target);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tests_run += 6;
            if (o_wren[d] !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_wren[%0d]: got %0h, expected 0", d, o_wren[d]); end
            if (o_din[d] !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_din[%0d]: got %0h, expected 0", d, o_din[d]); end
            if (o_del[d] !== 1'b0)  begin tests_failed++; $display("[TB] FAIL reset_del[%0d]: got %0b, expected 0", d, o_del[d]); end
            if (done[d] !== 1'b0)   begin tests_failed++; $display("[TB] FAIL reset_done[%0d]: got %0b, expected 0", d, done[d]); end
            if (trunc[d] !== 1'b0)  begin tests_failed++; $display("[TB] FAIL reset_trunc[%0d]: got %0b, expected 0", d, trunc[d]); end
            if (h_rden[d] !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_hrden[%0d]: got %0b, expected 0", d, h_rden[d]); end
        end
        @(negedge clk);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_unicast();
        int w0 = wcnt[0];
        int d0 = done_cnt[0];
        int n;
        push_frame(0, 4'b0100, 46, 8'h40);
        wait_done(0, d0 + 1, 300);
        n = wcnt[0] - w0;
        tests_run++;
        if (n != 60) begin tests_failed++; $display("[TB] FAIL uni_count: got %0d writes, expected 60", n); end
        for (int k = 0; k < n && k < 60; k++) begin
            tests_run++;
            if ({wdin[0][w0+k], wmask[0][w0+k], wdel[0][w0+k]} !== {exp_byte(HDR, 8'h40, k), 4'b0100, k == 59}) begin
                tests_failed++;
                $display("[TB] FAIL uni_write%0d: got din=%0h wren=%0b del=%0b, expected din=%0h wren=0100 del=%0b",
                         k, wdin[0][w0+k], wmask[0][w0+k], wdel[0][w0+k], exp_byte(HDR, 8'h40, k), k == 59);
            end
        end
        if (n >= 60) begin
            tests_run++;
            if (wcyc[0][w0+59] - wcyc[0][w0] != 59) begin
                tests_failed++;
                $display("[TB] FAIL uni_span: got %0d cycles, expected 59", wcyc[0][w0+59] - wcyc[0][w0]);
            end
        end
        tests_run++;
        if (done_cnt[0] - d0 != 1) begin tests_failed++; $display("[TB] FAIL uni_done: got %0d pulses, expected 1", done_cnt[0] - d0); end
    endtask

    task automatic test_broadcast();
        int w0 = wcnt[0];
        int d0 = done_cnt[0];
        int n;
        push_frame(0, 4'b1011, 46, 8'h80);
        wait_done(0, d0 + 1, 300);
        n = wcnt[0] - w0;
        tests_run++;
        if (n != 60) begin tests_failed++; $display("[TB] FAIL bc_count: got %0d writes, expected 60", n); end
        for (int k = 0; k < n && k < 60; k++) begin
            tests_run++;
            if ({wdin[0][w0+k], wmask[0][w0+k], wdel[0][w0+k]} !== {exp_byte(HDR, 8'h80, k), 4'b1011, k == 59}) begin
                tests_failed++;
                $display("[TB] FAIL bc_write%0d: got din=%0h wren=%0b del=%0b, expected din=%0h wren=1011 del=%0b",
                         k, wdin[0][w0+k], wmask[0][w0+k], wdel[0][w0+k], exp_byte(HDR, 8'h80, k), k == 59);
            end
        end
    endtask

    task automatic test_afull();
        int w0 = wcnt[0];
        int h0 = hrd[0];
        int d0 = done_cnt[0];
        afull[0] = 4'b0001;
        push_frame(0, 4'b0011, 46, 8'hC0);
        repeat (20) @(negedge clk);
        tests_run += 3;
        if (hrd[0] != h0)      begin tests_failed++; $display("[TB] FAIL afull_block_pop: got %0d pops, expected 0", hrd[0] - h0); end
        if (wcnt[0] != w0)     begin tests_failed++; $display("[TB] FAIL afull_block_wr: got %0d writes, expected 0", wcnt[0] - w0); end
        if (h_rden[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL afull_block_rden: got %0b, expected 0", h_rden[0]); end
        afull[0] = 4'b0000;
        @(negedge clk);
        tests_run++;
        if (hrd[0] != h0 + 1) begin tests_failed++; $display("[TB] FAIL afull_release: got %0d pops, expected 1", hrd[0] - h0); end
        wait_done(0, d0 + 1, 300);
        tests_run += 2;
        if (wcnt[0] - w0 != 60) begin tests_failed++; $display("[TB] FAIL afull_count: got %0d writes, expected 60", wcnt[0] - w0); end
        else if (wmask[0][w0+59] !== 4'b0011 || wdel[0][w0+59] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL afull_last: got wren=%0b del=%0b, expected wren=0011 del=1", wmask[0][w0+59], wdel[0][w0+59]);
        end
        afull[0] = 4'b0100;
        h0 = hrd[0];
        d0 = done_cnt[0];
        push_frame(0, 4'b0011, 46, 8'hD0);
        repeat (2) @(negedge clk);
        if (hrd[0] != h0 + 1) begin tests_failed++; $display("[TB] FAIL afull_unmasked: got %0d pops, expected 1", hrd[0] - h0); end
        wait_done(0, d0 + 1, 300);
        afull[0] = 4'b0000;
    endtask

    task automatic test_stall();
        int w0 = wcnt[0];
        int d0 = done_cnt[0];
        int n;
        stall_idx[0] = bwr[0] + 10;
        push_frame(0, 4'b0001, 46, 8'h10);
        wait_done(0, d0 + 1, 300);
        stall_idx[0] = -1;
        n = wcnt[0] - w0;
        tests_run++;
        if (n != 60) begin tests_failed++; $display("[TB] FAIL stall_count: got %0d writes, expected 60", n); end
        for (int k = 0; k < n && k < 60; k++) begin
            tests_run++;
            if ({wdin[0][w0+k], wdel[0][w0+k]} !== {exp_byte(HDR, 8'h10, k), k == 59}) begin
                tests_failed++;
                $display("[TB] FAIL stall_write%0d: got din=%0h del=%0b, expected din=%0h del=%0b",
                         k, wdin[0][w0+k], wdel[0][w0+k], exp_byte(HDR, 8'h10, k), k == 59);
            end
        end
        if (n >= 60) begin
            tests_run += 3;
            if (wcyc[0][w0+23] - wcyc[0][w0+22] != 1) begin tests_failed++; $display("[TB] FAIL stall_gap_before: got %0d, expected 1", wcyc[0][w0+23] - wcyc[0][w0+22]); end
            if (wcyc[0][w0+24] - wcyc[0][w0+23] != 6) begin tests_failed++; $display("[TB] FAIL stall_gap: got %0d, expected 6", wcyc[0][w0+24] - wcyc[0][w0+23]); end
            if (wcyc[0][w0+25] - wcyc[0][w0+24] != 1) begin tests_failed++; $display("[TB] FAIL stall_gap_after: got %0d, expected 1", wcyc[0][w0+25] - wcyc[0][w0+24]); end
        end
    endtask

    task automatic test_trunc();
        int w0 = wcnt[1];
        int d0 = done_cnt[1];
        int t0 = trunc_cnt[1];
        int n;
        push_frame(1, 4'b0010, 20, 8'h20);
        wait_done(1, d0 + 1, 200);
        n = wcnt[1] - w0;
        tests_run += 3;
        if (n != 30) begin tests_failed++; $display("[TB] FAIL trunc_count: got %0d writes, expected 30", n); end
        if (trunc_cnt[1] - t0 != 1) begin tests_failed++; $display("[TB] FAIL trunc_pulse: got %0d, expected 1", trunc_cnt[1] - t0); end
        if (brd[1] != bwr[1]) begin tests_failed++; $display("[TB] FAIL trunc_drain: got %0d bytes left, expected 0", bwr[1] - brd[1]); end
        for (int k = 0; k < n && k < 30; k++) begin
            tests_run++;
            if ({wdin[1][w0+k], wmask[1][w0+k], wdel[1][w0+k]} !== {exp_byte(HDR, 8'h20, k), 4'b0010, k == 29}) begin
                tests_failed++;
                $display("[TB] FAIL trunc_write%0d: got din=%0h wren=%0b del=%0b, expected din=%0h wren=0010 del=%0b",
                         k, wdin[1][w0+k], wmask[1][w0+k], wdel[1][w0+k], exp_byte(HDR, 8'h20, k), k == 29);
            end
        end
        w0 = wcnt[1];
        d0 = done_cnt[1];
        t0 = trunc_cnt[1];
        push_frame(1, 4'b0010, 10, 8'h50);
        wait_done(1, d0 + 1, 200);
        n = wcnt[1] - w0;
        tests_run += 2;
        if (n != 24) begin tests_failed++; $display("[TB] FAIL trunc_next_count: got %0d writes, expected 24", n); end
        if (trunc_cnt[1] != t0) begin tests_failed++; $display("[TB] FAIL trunc_next_pulse: got %0d, expected 0", trunc_cnt[1] - t0); end
        for (int k = 0; k < n && k < 24; k++) begin
            tests_run++;
            if ({wdin[1][w0+k], wdel[1][w0+k]} !== {exp_byte(HDR, 8'h50, k), k == 23}) begin
                tests_failed++;
                $display("[TB] FAIL trunc_next_write%0d: got din=%0h del=%0b, expected din=%0h del=%0b",
                         k, wdin[1][w0+k], wdel[1][w0+k], exp_byte(HDR, 8'h50, k), k == 23);
            end
        end
    endtask

    task automatic test_mask0_reset();
        int w0 = wcnt[0];
        int d0 = done_cnt[0];
        int n;
        int t;
        push_frame(0, 4'b0000, 8, 8'h60);
        push_frame(0, 4'b1000, 46, 8'h70);
        wait_done(0, d0 + 2, 400);
        n = wcnt[0] - w0;
        tests_run++;
        if (n != 60) begin tests_failed++; $display("[TB] FAIL mask0_count: got %0d writes, expected 60", n); end
        for (int k = 0; k < n && k < 60; k++) begin
            tests_run++;
            if ({wdin[0][w0+k], wmask[0][w0+k], wdel[0][w0+k]} !== {exp_byte(HDR, 8'h70, k), 4'b1000, k == 59}) begin
                tests_failed++;
                $display("[TB] FAIL mask0_write%0d: got din=%0h wren=%0b del=%0b, expected din=%0h wren=1000 del=%0b",
                         k, wdin[0][w0+k], wmask[0][w0+k], wdel[0][w0+k], exp_byte(HDR, 8'h70, k), k == 59);
            end
        end
        w0 = wcnt[0];
        push_frame(0, 4'b0100, 46, 8'h90);
        t = 0;
        while (wcnt[0] - w0 < 8 && t < 100) begin
            @(negedge clk);
            t++;
        end
        tests_run++;
        if (t >= 100) begin tests_failed++; $display("[TB] FAIL rst_reach_hdr7: got %0d writes, expected 8", wcnt[0] - w0); end
        arst_n = 1'b0;
        @(negedge clk);
        tests_run += 5;
        if (o_wren[0] !== 4'h0) begin tests_failed++; $display("[TB] FAIL rst_wren: got %0h, expected 0", o_wren[0]); end
        if (o_din[0] !== 8'h00) begin tests_failed++; $display("[TB] FAIL rst_din: got %0h, expected 0", o_din[0]); end
        if (o_del[0] !== 1'b0)  begin tests_failed++; $display("[TB] FAIL rst_del: got %0b, expected 0", o_del[0]); end
        if (done[0] !== 1'b0)   begin tests_failed++; $display("[TB] FAIL rst_done: got %0b, expected 0", done[0]); end
        if (u_a.state !== ST_IDLE) begin tests_failed++; $display("[TB] FAIL rst_state: got %0d, expected %0d", u_a.state, ST_IDLE); end
        repeat (3) @(negedge clk);
        tests_run++;
        if (wcnt[0] - w0 >= 14) begin tests_failed++; $display("[TB] FAIL rst_abandon: got %0d writes, expected < 14", wcnt[0] - w0); end
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
        w0 = wcnt[0];
        d0 = done_cnt[0];
        push_frame(0, 4'b0100, 46, 8'hA0);
        wait_done(0, d0 + 1, 300);
        n = wcnt[0] - w0;
        tests_run++;
        if (n != 60) begin tests_failed++; $display("[TB] FAIL post_rst_count: got %0d writes, expected 60", n); end
        for (int k = 0; k < n && k < 60; k++) begin
            tests_run++;
            if ({wdin[0][w0+k], wmask[0][w0+k], wdel[0][w0+k]} !== {exp_byte(HDR, 8'hA0, k), 4'b0100, k == 59}) begin
                tests_failed++;
                $display("[TB] FAIL post_rst_write%0d: got din=%0h wren=%0b del=%0b, expected din=%0h wren=0100 del=%0b",
                         k, wdin[0][w0+k], wmask[0][w0+k], wdel[0][w0+k], exp_byte(HDR, 8'hA0, k), k == 59);
            end
        end
    endtask

    initial begin
        afull[0]     = 4'b0000;
        afull[1]     = 4'b0000;
        stall_idx[0] = -1;
        stall_idx[1] = -1;
        test_reset();
        test_unicast();
        test_broadcast();
        test_afull();
        test_stall();
        test_trunc();
        test_mask0_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
